// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bubble_sort_pkg                                        |
// | Description : Shared types for the bubble sort engine.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package bubble_sort_pkg;

  // Engine sequencing: one READ/SWAP pair per compare step.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SWAP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bubble_sort_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bubble_sort_engine_if                                  |
// | Description : Load / control / readback bundle of the sort engine.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface bubble_sort_engine_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              descending;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [PW-1:0]     pass_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, descending, rd_addr,
    input  rd_data, busy, done, pass_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, descending, rd_addr,
    output rd_data, busy, done, pass_count
  );

endinterface
`default_nettype wire

// File: rtl/bubble_sort_engine_sort_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sort_cmp                                               |
// | Description : Order compare; swap when the pair is out of order.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sort_cmp #(
  parameter int DATA_W = 4
) (
  input  wire logic [DATA_W-1:0] a,
  input  wire logic [DATA_W-1:0] b,
  input  wire logic              descending,
  output logic                   swap
);

  // Unsigned compare; equal values never swap so the sort stays stable.
  assign swap = descending ? (a < b) : (a > b);

endmodule
`default_nettype wire

// File: rtl/bubble_sort_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bubble_sort_engine                                     |
// | Description : In-place bubble sort over a small register file with   |
// |               early exit when a pass makes no swap.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module bubble_sort_engine
  import bubble_sort_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  bubble_sort_engine_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [AW-1:0]     r_i;
  logic [AW-1:0]     r_j;
  logic              r_mode;
  logic              r_swapped;
  logic [PW-1:0]     r_pass_count;
  logic [AW-1:0]     w_j1;
  logic              w_swap;
  logic              w_last_step;
  logic              w_final_pass;

  // Second element of the current pair; never exceeds DEPTH-1.
  assign w_j1 = r_j + AW'(1);

  // Last pair of this pass: the tail beyond DEPTH-1-i is already in place.
  assign w_last_step = int'(r_j) >= (DEPTH - 2 - int'(r_i));

  // Stop after a pass with no swap (counting this step) or after the last pass.
  assign w_final_pass = !(r_swapped || w_swap) || (int'(r_i) == DEPTH - 2);

  sort_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .a         (r_a),
    .b         (r_b),
    .descending(r_mode),
    .swap      (w_swap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = READ;
      READ:    w_state_next = SWAP;
      SWAP:    w_state_next = (w_last_step && w_final_pass) ? DONE : READ;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Storage, pair latches and pass/pair indices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_mode       <= 1'b0;
      r_swapped    <= 1'b0;
      r_pass_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A write coinciding with start lands before the first READ.
          if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) r_mem[bus.wr_addr] <= bus.wr_data;
          if (bus.start) begin
            r_i       <= '0;
            r_j       <= '0;
            r_swapped <= 1'b0;
            r_mode    <= bus.descending;
          end
        end
        READ: begin
          r_a <= r_mem[r_j];
          r_b <= r_mem[w_j1];
        end
        SWAP: begin
          if (w_swap) begin
            r_mem[r_j]  <= r_b;
            r_mem[w_j1] <= r_a;
          end
          if (!w_last_step) begin
            r_j       <= r_j + AW'(1);
            r_swapped <= r_swapped | w_swap;
          end else if (w_final_pass) begin
            r_pass_count <= PW'(r_i) + PW'(1);
          end else begin
            r_i       <= r_i + AW'(1);
            r_j       <= '0;
            r_swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_data    = (int'(bus.rd_addr) < DEPTH) ? r_mem[bus.rd_addr] : '0;
  assign bus.busy       = (r_state == READ) || (r_state == SWAP);
  assign bus.done       = (r_state == DONE);
  assign bus.pass_count = r_pass_count;

endmodule
`default_nettype wire

// File: doc/bubble_sort_engine.md
BUBBLE_SORT_ENGINE -- requirements
Module: bubble_sort_engine

Interface
REQ-001 Parameter DATA_W, default 4: element width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4: number of elements; SHALL be at least 2.
REQ-003 Derived AW = $clog2(DEPTH); PW = $clog2(DEPTH)+1.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 wr_en  in  1  element write strobe.
REQ-007 wr_addr  in  AW  element index to write.
REQ-008 wr_data  in  DATA_W  element value.
REQ-009 start  in  1  single-cycle sort request.
REQ-010 descending  in  1  sort order: 0 = ascending, 1 = descending.
REQ-011 rd_addr  in  AW  element index to read.
REQ-012 rd_data  out  DATA_W  combinational mem[rd_addr].
REQ-013 busy  out  1  high while a sort is in progress.
REQ-014 done  out  1  one-cycle pulse when a sort completes.
REQ-015 pass_count  out  PW  number of passes executed by the last sort; held until the next start.

Function
REQ-016 Storage SHALL be DEPTH registers of DATA_W bits.
REQ-017 In IDLE, wr_en SHALL write wr_data to mem[wr_addr] at the clock edge.
REQ-018 wr_addr >= DEPTH SHALL be ignored; rd_addr >= DEPTH SHALL return 0.
REQ-019 While busy, wr_en and start SHALL be ignored.
REQ-020 If wr_en and start are both high in IDLE, the write SHALL commit in that cycle, and the sort SHALL include the written value.
REQ-021 The FSM SHALL have four states: IDLE, READ, SWAP, DONE.
REQ-022 Transitions:
- IDLE: start -> READ.
- READ -> SWAP, always.
- SWAP -> READ, DONE or READ (next pass), per REQ-025.
- DONE -> IDLE, always.
REQ-023 On start, the engine SHALL:
- clear pass index i, pair index j and the swapped flag;
- latch descending into an internal mode register, which controls the sort for its whole duration.
REQ-024 READ SHALL latch A = mem[j] and B = mem[j+1].
REQ-025 SWAP behaviour:
- swap condition: A>B (ascending) or A<B (descending), unsigned compare; equal values SHALL NOT swap.
- on swap, write mem[j] = B and mem[j+1] = A, and set the swapped flag.
- if j < DEPTH-2-i: j++, go to READ.
- else, if no swap occurred this pass (this step included) or i == DEPTH-2: go to DONE.
- else: i++, j = 0, swapped flag cleared, go to READ.
REQ-026 pass_count SHALL equal i+1 on entering DONE.
REQ-027 busy SHALL be high exactly in READ and SWAP; done SHALL be high exactly in DONE.
REQ-028 Latency: done SHALL assert 2*P+1 cycles after the start edge, where P is the number of compare steps executed.
REQ-029 Worst case: P = DEPTH*(DEPTH-1)/2. Best case (input already sorted): P = DEPTH-1.
REQ-030 rd_data SHALL reflect in-progress contents during a sort.

Reset
REQ-031 When rst_n=0, on the clock edge:
- state = IDLE;
- all mem entries, A, B, i, j, mode register, swapped flag and pass_count = 0;
- busy = 0, done = 0.
REQ-032 Reset mid-sort SHALL abort the sort without a done pulse; contents SHALL be cleared.

Structure
REQ-033 Package bubble_sort_pkg SHALL hold the FSM state enum typedef.
REQ-034 A sub-module sort_cmp (inputs a, b, descending; output swap) SHALL implement the order compare.
REQ-035 The top level SHALL contain the storage, the index counters and the FSM.

Verification (DATA_W=4, DEPTH=4 unless stated)
REQ-036 Load [4,3,2,1], start, ascending -> done 13 cycles after start; contents [1,2,3,4]; pass_count = 3.
REQ-037 Load [1,2,3,4], start, ascending -> done 7 cycles after start; contents unchanged; pass_count = 1.
REQ-038 Load [2,9,2,5], start with descending=1 -> contents [9,5,2,2]; the descending value held through the sort.
REQ-039 wr_en to addr 0 with value 15 and start in the same cycle, contents otherwise [0,3,2,1] -> result [1,2,3,15]; writes during busy have no effect.
REQ-040 Assert rst_n=0 on the 5th busy cycle -> busy=0 next cycle, no done pulse, all rd_data = 0; a following load and sort completes correctly.
REQ-041 DEPTH=5, DATA_W=8, load [200,7,7,0,255] -> result [0,7,7,200,255]; rd_addr=5..7 returns 0; writes to addr 5..7 are ignored.
